// File: rtl/bus_timer_slave.sv
// -----------------------------------------------------------------------------
// bus_timer_slave
//
// Word-addressed bus responder hosting a 32-bit interval timer with a level
// interrupt. One access is accepted when cs_ and as_ are both low in IDLE. The
// response is a single-cycle active-low rdy_ pulse with registered rd_data.
//
// Register map (addr):
//   0 CTRL    bit0 start, bit1 periodic
//   1 INTR    bit0 flag (write 1 to clear)
//   2 EXPR    32-bit expiry value
//   3 COUNTER 32-bit count, read/write
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_   in   synchronous active-low reset
//   cs_      in   chip select, active-low
//   as_      in   address strobe, active-low
//   rw       in   1 = read, 0 = write
//   addr     in   [1:0] word address
//   wr_data  in   [31:0] write data
//   rd_data  out  [31:0] read data, registered, 0 outside the ACK cycle
//   rdy_     out  access complete, active-low, one cycle per access
//   irq      out  interrupt, registered copy of INTR.flag
//
// Configuration macro: BUS_TIMER_WAIT_EN
//   defined   -> WAIT state and 4-bit wait counter; WAIT_CYCLES (1..15) extra
//                cycles per access
//   undefined -> IDLE goes straight to ACK, WAIT_CYCLES is ignored
// -----------------------------------------------------------------------------
module bus_timer_slave #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        cs_,
    input  logic        as_,
    input  logic        rw,
    input  logic [1:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

`ifdef BUS_TIMER_WAIT_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
    logic [3:0]  r_wait_cnt;
`endif

    // Bus FSM state and latched request
    state_t      r_state;
    logic [1:0]  r_addr;
    logic        r_rw;
    logic [31:0] r_wdata;
    logic [31:0] r_rd_data;
    logic        r_rdy_n;

    // Timer registers
    logic [31:0] r_counter;
    logic [31:0] r_expr;
    logic        r_start;
    logic        r_periodic;
    logic        r_flag;

    // Combinational next-state and decode
    logic        w_req;
    logic        w_commit;
    logic        w_wr_ctrl;
    logic        w_wr_intr;
    logic        w_wr_expr;
    logic        w_wr_cnt;
    logic        w_expire;
    logic [31:0] w_counter_nxt;
    logic [31:0] w_expr_nxt;
    logic        w_start_nxt;
    logic        w_periodic_nxt;
    logic        w_flag_nxt;
    logic        w_rd_rw;
    logic [1:0]  w_rd_addr;
    logic [31:0] w_rd_word;
    logic [31:0] w_rd_val;

    assign rd_data = r_rd_data;
    assign rdy_    = r_rdy_n;
    assign irq     = r_flag;

    // Request decode, write strobes and timer next-state with event priorities
    always_comb begin
        w_req     = ~cs_ & ~as_;
        // Writes take effect on the edge that leaves ACK
        w_commit  = (r_state == ST_ACK) & ~r_rw;
        w_wr_ctrl = w_commit & (r_addr == 2'd0);
        w_wr_intr = w_commit & (r_addr == 2'd1);
        w_wr_expr = w_commit & (r_addr == 2'd2);
        w_wr_cnt  = w_commit & (r_addr == 2'd3);
        w_expire  = r_start & (r_counter == r_expr);

        // A bus write to COUNTER overrides both increment and expiry reload
        if (w_wr_cnt) begin
            w_counter_nxt = r_wdata;
        end else if (w_expire) begin
            w_counter_nxt = 32'd0;
        end else if (r_start) begin
            w_counter_nxt = r_counter + 32'd1;
        end else begin
            w_counter_nxt = r_counter;
        end

        // A bus write to CTRL overrides the one-shot auto-clear of start
        if (w_wr_ctrl) begin
            w_start_nxt    = r_wdata[0];
            w_periodic_nxt = r_wdata[1];
        end else if (w_expire && !r_periodic) begin
            w_start_nxt    = 1'b0;
            w_periodic_nxt = r_periodic;
        end else begin
            w_start_nxt    = r_start;
            w_periodic_nxt = r_periodic;
        end

        // An expiry in the same cycle wins over a write-1-to-clear
        if (w_expire) begin
            w_flag_nxt = 1'b1;
        end else if (w_wr_intr && r_wdata[0]) begin
            w_flag_nxt = 1'b0;
        end else begin
            w_flag_nxt = r_flag;
        end

        if (w_wr_expr) begin
            w_expr_nxt = r_wdata;
        end else begin
            w_expr_nxt = r_expr;
        end
    end

    // Read data for the cycle entering ACK; uses next-state values so a
    // read returns what the register holds during the ACK cycle itself
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_rd_rw   = rw;
            w_rd_addr = addr;
        end else begin
            w_rd_rw   = r_rw;
            w_rd_addr = r_addr;
        end

        case (w_rd_addr)
            2'd0:    w_rd_word = {30'd0, w_periodic_nxt, w_start_nxt};
            2'd1:    w_rd_word = {31'd0, w_flag_nxt};
            2'd2:    w_rd_word = w_expr_nxt;
            2'd3:    w_rd_word = w_counter_nxt;
            default: w_rd_word = 32'd0;
        endcase

        if (w_rd_rw) begin
            w_rd_val = w_rd_word;
        end else begin
            w_rd_val = 32'd0;
        end
    end

    // Bus FSM with registered rdy_ and rd_data
    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_state   <= ST_IDLE;
            r_addr    <= 2'd0;
            r_rw      <= 1'b0;
            r_wdata   <= 32'd0;
            r_rd_data <= 32'd0;
            r_rdy_n   <= 1'b1;
`ifdef BUS_TIMER_WAIT_EN
            r_wait_cnt <= 4'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr  <= addr;
                        r_rw    <= rw;
                        r_wdata <= wr_data;
`ifdef BUS_TIMER_WAIT_EN
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= WAIT_LOAD;
                        r_rdy_n    <= 1'b1;
                        r_rd_data  <= 32'd0;
`else
                        r_state   <= ST_ACK;
                        r_rdy_n   <= 1'b0;
                        r_rd_data <= w_rd_val;
`endif
                    end else begin
                        r_state   <= ST_IDLE;
                        r_rdy_n   <= 1'b1;
                        r_rd_data <= 32'd0;
                    end
                end
`ifdef BUS_TIMER_WAIT_EN
                ST_WAIT: begin
                    // cs_/as_ are not looked at while waiting
                    if (r_wait_cnt == 4'd0) begin
                        r_state   <= ST_ACK;
                        r_rdy_n   <= 1'b0;
                        r_rd_data <= w_rd_val;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                        r_rdy_n    <= 1'b1;
                        r_rd_data  <= 32'd0;
                    end
                end
`endif
                ST_ACK: begin
                    r_state   <= ST_IDLE;
                    r_rdy_n   <= 1'b1;
                    r_rd_data <= 32'd0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_rdy_n   <= 1'b1;
                    r_rd_data <= 32'd0;
                end
            endcase
        end
    end

    // Timer register update
    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_counter  <= 32'd0;
            r_expr     <= 32'd0;
            r_start    <= 1'b0;
            r_periodic <= 1'b0;
            r_flag     <= 1'b0;
        end else begin
            r_counter  <= w_counter_nxt;
            r_expr     <= w_expr_nxt;
            r_start    <= w_start_nxt;
            r_periodic <= w_periodic_nxt;
            r_flag     <= w_flag_nxt;
        end
    end

endmodule

// File: tb/tb_bus_timer_slave.sv
module tb_bus_timer_slave;

    localparam int WAIT_CYCLES = 2;
`ifdef BUS_TIMER_WAIT_EN
    localparam int LAT = WAIT_CYCLES + 1;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_;
    logic        cs_;
    logic        as_;
    logic        rw;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rdy_;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bus_timer_slave #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk     (clk),
        .reset_  (reset_),
        .cs_     (cs_),
        .as_     (as_),
        .rw      (rw),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .rdy_    (rdy_),
        .irq     (irq)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Bus: an accepted access answers LAT edges later and commits one edge
    // after that; the slave is deaf until the edge after the commit.
    longint      edge_n = 0;
    longint      m_free_at = 0;
    longint      m_ack_edge = -1;
    longint      m_commit_edge = -1;
    bit [1:0]    m_a;
    bit          m_rw;
    bit [31:0]   m_wd;
    bit [31:0]   m_cnt, m_expr;
    bit          m_start, m_per, m_flag, m_hit;
    bit          m_rdy_exp = 1'b1;
    bit [31:0]   m_rd_exp = 32'd0;

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (reset_ !== 1'b1) begin
            m_cnt = 0; m_expr = 0; m_start = 0; m_per = 0; m_flag = 0;
            m_free_at = edge_n + 1; m_ack_edge = -1; m_commit_edge = -1;
            m_rdy_exp = 1'b1; m_rd_exp = 32'd0;
        end else begin
            // timer rule for this cycle
            m_hit = m_start && (m_cnt == m_expr);
            if (m_hit) begin
                m_cnt  = 32'd0;
                m_flag = 1'b1;
                if (!m_per) m_start = 1'b0;
            end else if (m_start) begin
                m_cnt = m_cnt + 32'd1;
            end
            // bus write overrides according to the priority rules
            if (edge_n == m_commit_edge && !m_rw) begin
                case (m_a)
                    2'd0:    begin m_start = m_wd[0]; m_per = m_wd[1]; end
                    2'd1:    if (m_wd[0] && !m_hit) m_flag = 1'b0;
                    2'd2:    m_expr = m_wd;
                    default: m_cnt = m_wd;
                endcase
            end
            if (edge_n >= m_free_at && cs_ === 1'b0 && as_ === 1'b0) begin
                m_a = addr; m_rw = rw; m_wd = wr_data;
                m_ack_edge    = edge_n + LAT - 1;
                m_commit_edge = edge_n + LAT;
                m_free_at     = edge_n + LAT + 1;
            end
            m_rdy_exp = (edge_n == m_ack_edge) ? 1'b0 : 1'b1;
            m_rd_exp  = 32'd0;
            if (edge_n == m_ack_edge && m_rw) begin
                case (m_a)
                    2'd0:    m_rd_exp = {30'd0, m_per, m_start};
                    2'd1:    m_rd_exp = {31'd0, m_flag};
                    2'd2:    m_rd_exp = m_expr;
                    default: m_rd_exp = m_cnt;
                endcase
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdy_", 64'(rdy_), 64'(m_rdy_exp));
            chk("rd_data", 64'(rd_data), 64'(m_rd_exp));
            chk("irq", 64'(irq), 64'(m_flag));
        end
    end

    // ---------------- stimulus ----------------
    task automatic access(input logic [1:0] a, input logic r, input logic [31:0] d,
                          input bit hold, output logic [31:0] q, output int lat);
        @(negedge clk);
        cs_ = 1'b0; as_ = 1'b0; addr = a; rw = r; wr_data = d;
        lat = 0; q = 32'd0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (rdy_ === 1'b0) break;
        end
        if (rdy_ !== 1'b0) chk("access_timeout", 64'd0, 64'd1);
        else q = rd_data;
        if (hold) @(negedge clk);
        cs_ = 1'b1; as_ = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] q; int lat;
        access(a, 1'b0, d, 1'b0, q, lat);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] q);
        int lat;
        access(a, 1'b1, 32'd0, 1'b0, q, lat);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 2))
                0:       begin cs_ = 1'b1; as_ = 1'b1; end
                1:       begin cs_ = 1'b1; as_ = 1'b0; end
                default: begin cs_ = 1'b0; as_ = 1'b1; end
            endcase
            addr = 2'($urandom_range(0, 3)); rw = 1'($urandom_range(0, 1)); wr_data = $urandom;
        end
        cs_ = 1'b1; as_ = 1'b1;
    endtask

    initial begin
        logic [31:0] q;
        logic [31:0] d;
        int lat, pulses, p1, p2;
        logic [1:0] a;

        reset_ = 1'b0; cs_ = 1'b1; as_ = 1'b1; rw = 1'b0; addr = 2'd0; wr_data = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_rdy_", 64'(rdy_), 64'd1);
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        chk("reset_irq", 64'(irq), 64'd0);
        reset_ = 1'b1; chk_en = 1'b1;

        // EXPR write / readback and latency
        wr(2'd2, 32'h10);
        access(2'd2, 1'b1, 32'd0, 1'b0, q, lat);
        chk("expr_readback", 64'(q), 64'h10);
        chk("latency", 64'(lat), 64'(LAT));
        @(negedge clk);
        chk("rd_data_after_ack", 64'(rd_data), 64'd0);

        // one-shot EXPR=3: flag on 4th edge after commit
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 4) chk("oneshot_irq_early", 64'(irq), 64'd0);
            if (k == 5) chk("oneshot_irq", 64'(irq), 64'd1);
        end
        rd(2'd0, q); chk("oneshot_ctrl", 64'(q), 64'd0);
        rd(2'd3, q); chk("oneshot_cnt", 64'(q), 64'd0);
        wr(2'd1, 32'h1);
        @(negedge clk);
        chk("w1c_clear", 64'(irq), 64'd0);

        // periodic EXPR=2: expiries on edges 3, 6, ...; W1C committing on edge 6
        wr(2'd2, 32'd2);
        wr(2'd0, 32'h3);
        repeat (5 - LAT) @(negedge clk);
        wr(2'd1, 32'h1);
        @(negedge clk);
        chk("w1c_vs_expiry", 64'(irq), 64'd1);
        wr(2'd0, 32'h0);
        wr(2'd1, 32'h1);
        @(negedge clk);
        chk("periodic_stop_clear", 64'(irq), 64'd0);

        // counter wrap: FFFFFFFE -> FFFFFFFF -> 0 .. 5 -> expiry on edge 8
        wr(2'd2, 32'd5);
        wr(2'd3, 32'hFFFF_FFFE);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 8) chk("wrap_irq_early", 64'(irq), 64'd0);
            if (k == 9) chk("wrap_irq", 64'(irq), 64'd1);
        end
        rd(2'd3, q); chk("wrap_cnt_hold", 64'(q), 64'd0);

        // reset during ACK of an EXPR write
        @(negedge clk);
        cs_ = 1'b0; as_ = 1'b0; addr = 2'd2; rw = 1'b0; wr_data = 32'hAB;
        lat = 0;
        while (lat < 40 && rdy_ !== 1'b0) begin @(negedge clk); lat++; end
        chk("rst_ack_seen", 64'(rdy_), 64'd0);
        reset_ = 1'b0; cs_ = 1'b1; as_ = 1'b1;
        @(negedge clk);
        chk("rst_rdy_", 64'(rdy_), 64'd1);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        reset_ = 1'b1;
        rd(2'd2, q); chk("rst_expr", 64'(q), 64'd0);

        // not selected: no response
        @(negedge clk);
        cs_ = 1'b1; as_ = 1'b0; rw = 1'b1; addr = 2'd2;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("no_cs_rdy_", 64'(rdy_), 64'd1);
        end
        cs_ = 1'b1; as_ = 1'b1;

        // request held across ACK -> second pulse after one IDLE cycle
        @(negedge clk);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 2'd2;
        pulses = 0; p1 = 0; p2 = 0;
        for (int i = 0; i < 2 * LAT + 8; i++) begin
            @(negedge clk);
            if (rdy_ === 1'b0) begin
                pulses++;
                if (pulses == 1) p1 = i;
                if (pulses == 2) begin p2 = i; break; end
            end
        end
        cs_ = 1'b1; as_ = 1'b1;
        chk("held_pulses", 64'(pulses), 64'd2);
        chk("held_spacing", 64'(p2 - p1), 64'(LAT + 1));

        // randomized traffic, checked cycle by cycle against the model
        for (int n = 0; n < 250; n++) begin
            idle($urandom_range(0, 3));
            a = 2'($urandom_range(0, 3));
            case (a)
                2'd0:    d = 32'($urandom_range(0, 3));
                2'd1:    d = $urandom;
                2'd2:    d = 32'($urandom_range(0, 12));
                default: d = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                         : 32'($urandom_range(0, 12));
            endcase
            access(a, 1'($urandom_range(0, 1)), d, ($urandom_range(0, 7) == 0), q, lat);
        end
        repeat (LAT + 4) @(negedge clk);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
